tru_serial_nbit: RTL and testbench
==================================

TRU_SERIAL_NBIT -- requirements
Module: tru_serial_nbit

Interface
REQ-001 Parameter: N, default 8, operand and result width in bits (N >= 2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request new operation; sampled on rising clk.
REQ-005 mode  input  1  0 = subtract (A - B - bin), 1 = add (A + B + bin); sampled with start.
REQ-006 A  input  N  minuend / addend; sampled with start.
REQ-007 B  input  N  subtrahend / addend; sampled with start.
REQ-008 bin  input  1  borrow-in (sub) / carry-in (add); sampled with start.
REQ-009 busy  output  1  high while operation in progress.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 D  output  N  result, registered.
REQ-012 bo  output  1  borrow-out (sub) / carry-out (add), registered.
REQ-013 ovf  output  1  two's-complement signed overflow, registered.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; busy SHALL be 1 only in RUN, and done SHALL be 1 only in DONE.
REQ-015 In IDLE or DONE, start=1 SHALL latch A, B, bin and mode, clear the bit counter to 0, and enter RUN; start=0 SHALL cause IDLE to stay in IDLE and DONE to go to IDLE.
REQ-016 In RUN, start SHALL be ignored, and input changes SHALL have no effect on the operation in flight.
REQ-017 Each RUN cycle SHALL process one bit i (LSB first, i = counter): d_i = a_i ^ b_i ^ c; next c (sub) = (~a_i & b_i) | (~(a_i ^ b_i) & c); next c (add) = (a_i & b_i) | ((a_i ^ b_i) & c); the initial c SHALL be bin.
REQ-018 d_i SHALL go into an internal shift register; D, bo and ovf SHALL NOT change during RUN.
REQ-019 After the cycle that processes bit N-1, the FSM SHALL enter DONE; on that same edge D, bo (final c) and ovf SHALL update.
REQ-020 Latency: start sampled at edge k SHALL give done=1 in the cycle after edge k+N, and busy=1 in the cycles after edges k .. k+N-1.
REQ-021 ovf (sub) SHALL be (A[N-1] != B[N-1]) && (D[N-1] != A[N-1]); ovf (add) SHALL be (A[N-1] == B[N-1]) && (D[N-1] != A[N-1]), using the latched operands.
REQ-022 D, bo and ovf SHALL hold their values until the next operation completes.
REQ-023 Back-to-back: start=1 during DONE SHALL begin the next operation with no idle cycle; done pulses of consecutive operations SHALL be N+1 cycles apart.
REQ-024 The counter SHALL be ceil(log2 N) bits wide minimum and SHALL NOT wrap during RUN.
REQ-025 The result SHALL equal the N-bit truncation of A - B - bin (sub) or A + B + bin (add); bo=1 iff A < B + bin (sub) or the sum is >= 2^N (add).

Reset
REQ-026 rst=1 SHALL immediately, without a clock, force state IDLE, busy=0, done=0, D=0, bo=0, ovf=0 and clear the counter and shift register.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse; after release, operation SHALL begin only on a new start.
REQ-028 start asserted in the cycle rst deasserts SHALL be sampled on the first rising edge after deassertion.

Verification (N=4)
REQ-029 sub: A=0000, B=0001, bin=0 -> done after 4 cycles, D=1111, bo=1, ovf=0.
REQ-030 sub: A=1111, B=0001, bin=0 -> D=1110, bo=0, ovf=0; A=0001, B=0001, bin=1 -> D=1111, bo=1, ovf=0.
REQ-031 sub: A=1000, B=0001, bin=0 -> D=0111, bo=0, ovf=1; add: A=0111, B=0001, bin=0 -> D=1000, bo=0, ovf=1.
REQ-032 add: A=1111, B=0001, bin=0 -> D=0000, bo=1, ovf=0; changing A and B during RUN -> result unchanged.
REQ-033 start pulsed during RUN -> ignored, single done; start held high -> done pulses every 5 cycles with correct results.
REQ-034 rst pulsed at the 2nd RUN cycle -> outputs 0 immediately, no done; the next start produces a correct result.

Source files
------------

// File: rtl/tru_serial_nbit.sv
// tru_serial_nbit -- bit-serial N-bit adder/subtractor.
//
// One bit is processed per clock, LSB first. Operands are latched on start,
// so the inputs may change freely while the operation is in flight. The
// result, carry/borrow-out and signed overflow update together on the edge
// that processes bit N-1. They then hold until the next operation completes.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   begin an operation (honoured in IDLE and DONE, ignored in RUN)
//   mode   in   0 = A - B - bin, 1 = A + B + bin
//   A, B   in   N-bit operands
//   bin    in   borrow-in (sub) / carry-in (add)
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse, D/bo/ovf valid
//   D      out  N-bit result
//   bo     out  borrow-out (sub) / carry-out (add)
//   ovf    out  two's-complement overflow
module tru_serial_nbit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] D,
    output logic         bo,
    output logic         ovf
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   a_r, b_r, sh;
    logic           mode_r, c;
    logic [CW-1:0]  cnt;

    logic           ai, bi, di, c_nxt, ovf_nxt, last;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // output logic
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // one full-adder / full-subtractor slice, selected by the latched mode
    always_comb begin
        last  = (cnt == LAST);
        ai    = a_r[cnt];
        bi    = b_r[cnt];
        di    = ai ^ bi ^ c;
        c_nxt = mode_r ? ((ai & bi) | ((ai ^ bi) & c))
                       : ((~ai & bi) | (~(ai ^ bi) & c));
        // di is the result MSB on the last bit, so overflow can be formed
        // on the same edge that D is loaded.
        ovf_nxt = mode_r ? ((a_r[N-1] == b_r[N-1]) && (di != a_r[N-1]))
                         : ((a_r[N-1] != b_r[N-1]) && (di != a_r[N-1]));
    end

    // datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            mode_r <= 1'b0;
            c      <= 1'b0;
            cnt    <= '0;
            sh     <= '0;
            D      <= '0;
            bo     <= 1'b0;
            ovf    <= 1'b0;
        end else if (state != RUN) begin
            if (start) begin
                a_r    <= A;
                b_r    <= B;
                mode_r <= mode;
                c      <= bin;
                cnt    <= '0;
                sh     <= '0;
            end
        end else begin
            // result bits enter at the MSB so that after N shifts the word
            // is LSB-aligned
            sh <= {di, sh[N-1:1]};
            c  <= c_nxt;
            if (last) begin
                D   <= {di, sh[N-1:1]};
                bo  <= c_nxt;
                ovf <= ovf_nxt;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tru_serial_nbit.sv
module tb_tru_serial_nbit;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst, start, mode, bin;
    logic [N-1:0] A, B;
    logic         busy, done, bo, ovf;
    logic [N-1:0] D;

    tru_serial_nbit #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .A(A), .B(B),
        .bin(bin), .busy(busy), .done(done), .D(D), .bo(bo), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         m;
        logic [N-1:0] a, b;
        logic         bi;
        logic [N-1:0] d;
        logic         bo, ov;
    } vec_t;

    typedef struct packed {
        logic [N-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t         exp_q[$];
    int           errors = 0;
    int           checks = 0;
    logic [N-1:0] hold_d = '0;
    vec_t         vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("D", 32'(D), 32'(e.d));
                check("bo", 32'(bo), 32'(e.bo));
                check("ovf", 32'(ovf), 32'(e.ov));
            end
        end
    end

    // called at a negedge: drive start, push the expectation, let the edge
    // sample it, then scramble the inputs to show they are not reused
    task automatic issue(input vec_t v, input bit keep_start);
        start = 1'b1; mode = v.m; A = v.a; B = v.b; bin = v.bi;
        exp_q.push_back('{d: v.d, bo: v.bo, ov: v.ov});
        @(posedge clk);
        @(negedge clk);
        if (!keep_start) start = 1'b0;
        A = ~A; B = ~B; mode = ~mode; bin = ~bin;
    endtask

    // n = negedges seen since the sampling edge; returns at the done cycle
    task automatic wait_done(input int n0, input logic [N-1:0] newd, output int n);
        n = n0;
        check("busy_first", 32'(busy), 32'd1);
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) check("D_hold_run", 32'(D), 32'(hold_d));
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(N + 1));
        hold_d = newd;
    endtask

    initial begin
        int n;
        vt[0] = '{1'b0, 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0};
        vt[1] = '{1'b0, 4'b1111, 4'b0001, 1'b0, 4'b1110, 1'b0, 1'b0};
        vt[2] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b1111, 1'b1, 1'b0};
        vt[3] = '{1'b0, 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1};
        vt[4] = '{1'b1, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
        vt[5] = '{1'b1, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
        vt[6] = '{1'b1, 4'b0101, 4'b0011, 1'b1, 4'b1001, 1'b0, 1'b1};
        vt[7] = '{1'b0, 4'b0011, 4'b0101, 1'b1, 4'b1101, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; mode = 1'b0; A = '0; B = '0; bin = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_D", 32'(D), 32'd0);
        check("rst_bo", 32'(bo), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // directed single operations, with an idle cycle between them
        for (int i = 0; i < 8; i++) begin
            issue(vt[i], 1'b0);
            wait_done(1, vt[i].d, n);
            @(negedge clk);
            check("idle_after_done", 32'({busy, done}), 32'd0);
        end

        // start pulsed during RUN is ignored: only one done is produced
        issue(vt[1], 1'b0);
        start = 1'b1; A = 4'b0110; B = 4'b0010;
        @(negedge clk);
        start = 1'b0;
        wait_done(2, vt[1].d, n);
        repeat (3) @(negedge clk);

        // start held high: back-to-back operations, done every N+1 cycles
        issue(vt[0], 1'b1);
        wait_done(1, vt[0].d, n);
        issue(vt[4], 1'b1);
        wait_done(1, vt[4].d, n);
        issue(vt[6], 1'b0);
        wait_done(1, vt[6].d, n);
        @(negedge clk);

        // reset during the second RUN cycle aborts the operation
        start = 1'b1; mode = vt[5].m; A = vt[5].a; B = vt[5].b; bin = vt[5].bi;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_D", 32'(D), 32'd0);
        check("abort_bo", 32'(bo), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        hold_d = '0;
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);
        // start presented in the same cycle that reset drops
        rst = 1'b0;
        issue(vt[7], 1'b0);
        wait_done(1, vt[7].d, n);

        repeat (8) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
